instr_fetch: RTL

Instruction fetch unit: the initiator side of the instruction ROM read interface. It owns the program counter and drives `rom_ce`/`rom_pc` to the combinational instruction ROM. Each returned 32-bit word is captured into a small FIFO and offered to the decode stage over a valid/ready handshake. Control redirects from execute (jump/branch) flush the FIFO and restart fetch at the new target.

---
 rtl/instr_fetch_pkg.sv | 26 ++
 rtl/instr_fetch_if.sv | 31 +++
 rtl/fetch_fifo.sv | 51 +++++
 rtl/instr_fetch.sv | 87 ++++++++
 4 files changed

// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit: bus widths,
// the fetch state encoding and the {pc, instr} buffer entry.
package instr_fetch_pkg;

  localparam int INST_ADDR_W = 32;
  localparam int INST_W      = 32;

  localparam logic [INST_W-1:0]      ZERO_WORD = '0;
  localparam logic [INST_ADDR_W-1:0] PC_STEP   = 32'd4;

  typedef enum logic [1:0] {
    FETCH_WAIT = 2'd0,
    FETCH_RUN  = 2'd1,
    FETCH_HALT = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [INST_ADDR_W-1:0] pc;
    logic [INST_W-1:0]      instr;
  } fetch_entry_t;

  function automatic logic is_aligned(input logic [INST_ADDR_W-1:0] addr);
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-unit bus: ROM read port, execute redirect request and the
// valid/ready hand-off to decode. master = fetch unit, slave = its environment.
interface instr_fetch_if
  import instr_fetch_pkg::*;
();

  logic                   rom_ce;
  logic [INST_ADDR_W-1:0] rom_pc;
  logic [INST_W-1:0]      rom_instr;

  logic                   redirect_en;
  logic [INST_ADDR_W-1:0] redirect_pc;

  logic                   id_ready;
  logic                   id_valid;
  logic [INST_W-1:0]      id_instr;
  logic [INST_ADDR_W-1:0] id_pc;

  logic                   misalign_err;

  modport master (
    output rom_ce, rom_pc, id_valid, id_instr, id_pc, misalign_err,
    input  rom_instr, redirect_en, redirect_pc, id_ready
  );

  modport slave (
    input  rom_ce, rom_pc, id_valid, id_instr, id_pc, misalign_err,
    output rom_instr, redirect_en, redirect_pc, id_ready
  );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of {pc, instr} entries between ROM read and decode.
// Flush wins over push and pop; DEPTH must be a power of two.
module fetch_fifo
  import instr_fetch_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  fetch_entry_t     entry,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count,
  output fetch_entry_t     head
);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // NOTE: storage is deliberately not reset; count/empty qualify every read.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= entry;
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: owns the PC, reads the combinational ROM, buffers
// words in fetch_fifo and hands them to decode; execute redirects flush and restart.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [INST_ADDR_W-1:0] RESET_PC   = 32'h0000_0000,
  parameter int                     FIFO_DEPTH = 2
) (
  input logic          clk,
  input logic          rst,
  instr_fetch_if.master bus
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e           state_q, state_d;
  logic [INST_ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic                   misalign;
  logic                   rom_ce;
  logic                   push;
  logic                   pop;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [CNT_W-1:0]       fifo_count;
  fetch_entry_t           fifo_head;
  logic                   id_valid;

  // rom_ce depends only on registered state, never on id_ready.
  assign rom_ce   = (state_q == FETCH_RUN) && !fifo_full;
  assign push     = rom_ce && !bus.redirect_en;
  assign id_valid = (fifo_count != '0);
  assign pop      = id_valid && bus.id_ready;

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (bus.redirect_en),
    .entry ('{pc: fetch_pc_q, instr: bus.rom_instr}),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count),
    .head  (fifo_head)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FETCH_WAIT;
      fetch_pc_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no latches form.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    misalign   = 1'b0;
    if (bus.redirect_en) begin
      if (is_aligned(bus.redirect_pc)) begin
        fetch_pc_d = bus.redirect_pc;
        state_d    = FETCH_RUN;
      end else begin
        state_d  = FETCH_HALT;
        misalign = 1'b1;
      end
    end else begin
      unique case (state_q)
        FETCH_WAIT: state_d = FETCH_RUN;
        FETCH_RUN:  if (push) fetch_pc_d = fetch_pc_q + PC_STEP;
        FETCH_HALT: state_d = FETCH_HALT;
        default:    state_d = FETCH_WAIT;
      endcase
    end
  end

  assign bus.rom_ce       = rom_ce;
  assign bus.rom_pc       = fetch_pc_q;
  assign bus.id_valid     = id_valid;
  assign bus.id_instr     = fifo_empty ? ZERO_WORD : fifo_head.instr;
  assign bus.id_pc        = fifo_empty ? '0 : fifo_head.pc;
  assign bus.misalign_err = misalign && !rst;

endmodule
